// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - write-enable/flush pairs for the PC and the four pipeline latches.
interface hazard_ctrl_if;
  logic pc_wen;
  logic ifid_wen;
  logic ifid_flush;
  logic idex_wen;
  logic idex_flush;
  logic exmem_wen;
  logic exmem_flush;
  logic memwb_wen;
  logic memwb_flush;

  modport master (
    output pc_wen,
    output ifid_wen,
    output ifid_flush,
    output idex_wen,
    output idex_flush,
    output exmem_wen,
    output exmem_flush,
    output memwb_wen,
    output memwb_flush
  );

  modport slave (
    input pc_wen,
    input ifid_wen,
    input ifid_flush,
    input idex_wen,
    input idex_flush,
    input exmem_wen,
    input exmem_flush,
    input memwb_wen,
    input memwb_flush
  );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush control for the 5-stage pipeline, sticky halt and perf counters.
module hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             idex_dREN,
  input  logic [4:0]       idex_wsel,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             ex_taken,
  hazard_ctrl_if.master    ctl,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] dmiss_events
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] dmiss_q, dmiss_d;

  logic dmem_stall;
  logic load_use;

  assign dmem_stall = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use   = idex_dREN & (idex_wsel != 5'd0) &
                      ((idex_wsel == ifid_rs) | (ifid_uses_rt & (idex_wsel == ifid_rt)));

  always_comb begin
    state_d         = state_q;
    ctl.pc_wen      = 1'b0;
    ctl.ifid_wen    = 1'b0;
    ctl.ifid_flush  = 1'b0;
    ctl.idex_wen    = 1'b0;
    ctl.idex_flush  = 1'b0;
    ctl.exmem_wen   = 1'b0;
    ctl.exmem_flush = 1'b0;
    ctl.memwb_wen   = 1'b0;
    ctl.memwb_flush = 1'b0;

    if (RST) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN, DWAIT: begin
          if (dmem_stall) begin
            // Freeze everything upstream of MEM; WB gets a bubble.
            ctl.memwb_wen   = 1'b1;
            ctl.memwb_flush = 1'b1;
            state_d         = DWAIT;
          end else if (mem_halt) begin
            state_d = HALTED;
          end else begin
            state_d         = RUN;
            ctl.pc_wen      = 1'b1;
            ctl.ifid_wen    = 1'b1;
            ctl.idex_wen    = 1'b1;
            ctl.exmem_wen   = 1'b1;
            ctl.memwb_wen   = 1'b1;
            if (ex_taken) begin
              // Wrong-path fetch and decode are squashed, so a miss or load-use there is moot.
              ctl.ifid_flush = 1'b1;
              ctl.idex_flush = 1'b1;
            end else if (load_use) begin
              ctl.pc_wen     = 1'b0;
              ctl.ifid_wen   = 1'b0;
              ctl.idex_flush = 1'b1;
            end else if (!ihit) begin
              ctl.pc_wen     = 1'b0;
              ctl.ifid_flush = 1'b1;
            end
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    dmiss_d = dmiss_q;
    if (!ctl.pc_wen && (state_q != HALTED) && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
    if ((state_q == RUN) && (state_d == DWAIT) && (dmiss_q != {CNT_W{1'b1}})) begin
      dmiss_d = dmiss_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      stall_q <= '0;
      dmiss_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      dmiss_q <= dmiss_d;
    end
  end

  assign halt_o       = ~RST & (state_q == HALTED);
  assign stall_cycles = stall_q;
  assign dmiss_events = dmiss_q;

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline control unit for the 5-stage MIPS core: it drives the write-enable/flush pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable. It acts as the initiator for the latches' `wen`/`flush` interface.
- Stall sources: icache miss, dcache miss, load-use dependency.
- Flush source: a taken branch/jump resolved in EX.
- Other duties: latches the halt condition and keeps saturating stall/miss counters for the performance registers.

## Interface
Parameters
- CNT_W, 16, width of both performance counters.

Ports
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- ihit  in  1  instruction memory returned the fetch this cycle.
- dhit  in  1  data memory completed the access this cycle.
- mem_dREN  in  1  EX/MEM latch: load/LL in MEM stage.
- mem_dWEN  in  1  EX/MEM latch: store/SC in MEM stage.
- mem_halt  in  1  EX/MEM latch: halt instruction in MEM stage.
- idex_dREN  in  1  ID/EX latch: load in EX stage.
- idex_wsel  in  5  ID/EX latch: destination register of that instruction.
- ifid_rs  in  5  IF/ID latch: rs field.
- ifid_rt  in  5  IF/ID latch: rt field.
- ifid_uses_rt  in  1  decoded instruction in ID reads rt.
- ex_taken  in  1  branch taken or jump (pcselect≠0) resolved in EX.
- pc_wen  out  1  PC register enable.
- ifid_wen, ifid_flush  out  1 each  IF/ID latch control.
- idex_wen, idex_flush  out  1 each  ID/EX latch control.
- exmem_wen, exmem_flush  out  1 each  EX/MEM latch control.
- memwb_wen, memwb_flush  out  1 each  MEM/WB latch control.
- halt_o  out  1  core halted, sticky.
- stall_cycles  out  CNT_W  cycles with pc_wen=0 while not halted; saturating.
- dmiss_events  out  CNT_W  count of RUN→DWAIT transitions; saturating.

## Operation
- Latch semantics: wen=1, flush=0 loads the latch; wen=1, flush=1 inserts a bubble (zeroes); wen=0 holds the latch.
- Control outputs are combinational from the state and the current inputs.
- States: RUN, DWAIT, HALTED. Reset state is RUN.
- Decision logic in RUN/DWAIT, first matching rule wins:
  1. **Dmem stall** (`(mem_dREN|mem_dWEN) & !dhit`): pc, ifid, idex and exmem wen=0; memwb wen=1, flush=1.
  2. **Halt** (`mem_halt`): every wen=0. Next state HALTED.
  3. **Taken branch** (`ex_taken`): pc_wen=1 regardless of ihit; ifid and idex wen=1, flush=1; exmem and memwb advance.
  4. **Load-use** (`idex_dREN & idex_wsel≠0 & (idex_wsel==ifid_rs | (ifid_uses_rt & idex_wsel==ifid_rt))`): pc and ifid wen=0; idex wen=1, flush=1; exmem and memwb advance.
  5. **Imem miss** (`!ihit`): pc_wen=0; ifid wen=1, flush=1; the remaining latches advance.
  6. **Otherwise**: all wen=1, all flush=0.
- State transitions:
  - RUN→DWAIT when rule 1 applies.
  - DWAIT→RUN on the cycle where rule 1 no longer applies. In that cycle the rules are re-evaluated from rule 2, so the released cycle advances normally.
  - RUN/DWAIT→HALTED when rule 2 applies.
  - HALTED is exited only by RST.
- halt_o = (state==HALTED). In HALTED every wen=0 and every flush=0.
- Counters:
  - stall_cycles increments each cycle that pc_wen=0 and state≠HALTED.
  - dmiss_events increments on each RUN→DWAIT transition.
  - Both hold at 2^CNT_W−1 (saturate).

## Timing
- Stall/flush decisions take effect in the same cycle (zero latency); state and counters update at the rising edge of CLK.
- While RST=1: all wen=0, all flush=0, halt_o=0. At the edge with RST=1: state=RUN, both counters=0.
- RST asserted mid-DWAIT or in HALTED returns the unit to RUN at the next edge; pending memory handshakes are abandoned.
- A load-use condition lasts exactly one cycle by construction: after the bubble, the load has moved to MEM.
- Simultaneous dmem stall and ex_taken: the stall wins and the branch is held in EX. The flush occurs on the release cycle.
- Simultaneous ex_taken and load-use: the flush wins, because the ID instruction is wrong-path.
- A dhit that arrives in the same cycle the request appears triggers no stall and no state change.

## Test plan
- **Reset**: RST=1 for 2 cycles with ihit=1 → all wen=0, halt_o=0, stall_cycles=0, dmiss_events=0. After release with ihit=1 → all wen=1.
- **Dmem miss**: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 → pc_wen=0 for 3 cycles and memwb_flush=1. State is DWAIT for 3 cycles. dmiss_events=1, stall_cycles=3. The release cycle has all wen=1.
- **Load-use**: idex_dREN=1, idex_wsel=8, ifid_rs=8 → pc_wen=0, ifid_wen=0, idex_flush=1 for one cycle. Repeat with wsel=0 → no stall. Repeat with rt=8, uses_rt=0 → no stall.
- **Branch + miss priority**: ex_taken=1 with mem_dWEN=1, dhit=0 for 2 cycles, then dhit=1 → freeze for 2 cycles, then pc_wen=1 with ifid_flush=1 and idex_flush=1.
- **Halt**: mem_halt=1 → all wen=0 that cycle, then halt_o=1 sticky. Later ihit/ex_taken toggles have no effect. RST clears halt_o.
- **Counter saturation**: CNT_W=4, ihit=0 for 20 cycles → stall_cycles=15 and stays at 15.
